// File: rtl/led_seq_pkg.sv
// ----------------------------------------------------------------------------
// led_seq_pkg
// Shared types and constants for the LED shift-register sequencer.
//   seq_state_t      : sequencer FSM states (IDLE, SHIFT, DONE)
//   LED_WIDTH        : depth of the LED shift register (pattern length)
//   DEFAULT_TICK_DIV : default clock cycles per shift step
// ----------------------------------------------------------------------------
package led_seq_pkg;

    localparam int LED_WIDTH        = 10;
    localparam int DEFAULT_TICK_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/led_shift_sequencer_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Wrap-around counter 0..DIV-1 that produces a one-cycle tick on the terminal
// count while enabled.
//   clk      : system clock (rising edge)
//   reset    : synchronous active-high reset, counter -> 0
//   i_clear  : synchronous clear, counter -> 0 (restarts the step timing)
//   i_enable : count enable; tick is only produced while enabled
//   o_tick   : high for the cycle in which the counter sits at DIV-1
// ----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    // DIV=1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = i_enable && (r_cnt == TERM);

endmodule

// File: rtl/led_shift_sequencer.sv
// ----------------------------------------------------------------------------
// led_shift_sequencer
// Captures a parallel pattern and serialises it MSB-first toward the LED
// shift register, issuing one shift-enable pulse per TICK_DIV clock cycles.
// One-shot or repeating playback, with start/stop/busy/done handshake.
//   clk        : system clock (rising edge)
//   reset      : synchronous active-high reset
//   i_start    : playback request, accepted only in IDLE without i_stop
//   i_pattern  : pattern, captured on the accepted-start cycle
//   i_repeat   : captured with start; 1 = loop until stopped
//   i_stop     : abort playback (level or pulse)
//   o_val      : serial bit, pattern[o_bit_idx] in SHIFT, 0 elsewhere
//   o_shift_en : one-cycle pulse, shift register samples o_val on it
//   o_busy     : high while in SHIFT
//   o_done     : one-cycle pulse on normal completion (one-shot only)
//   o_bit_idx  : index of the bit currently presented on o_val
//
// Handshake: i_start is a request sampled on the rising edge; it is taken
// only when the FSM is IDLE and i_stop is low. o_busy rises the cycle after
// acceptance and o_done pulses once after the last shift of a one-shot pass.
// ----------------------------------------------------------------------------
module led_shift_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = LED_WIDTH,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [WIDTH-1:0]         i_pattern,
    input  logic                     i_repeat,
    input  logic                     i_stop,
    output logic                     o_val,
    output logic                     o_shift_en,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [$clog2(WIDTH)-1:0] o_bit_idx
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [WIDTH-1:0] r_pattern;
    logic             r_repeat;
    logic [IDX_W-1:0] r_bit_idx;

    logic w_accept;
    logic w_tick;
    logic w_presc_en;

    // Prescaler only runs in SHIFT; a stop in the same cycle freezes it so a
    // stop on the terminal count cannot produce a tick.
    assign w_presc_en = (r_state == SHIFT) && !i_stop;

    tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_presc (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_enable (w_presc_en),
        .o_tick   (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        o_shift_en = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_val      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !i_stop) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end
            end
            SHIFT: begin
                o_busy = 1'b1;
                o_val  = r_pattern[r_bit_idx];
                if (i_stop) begin
                    w_next = IDLE;
                end else if (w_tick) begin
                    o_shift_en = 1'b1;
                    if ((r_bit_idx == '0) && !r_repeat) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Pattern, repeat flag and bit index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= '0;
            r_repeat  <= 1'b0;
            r_bit_idx <= IDX_TOP;
        end else if (w_accept) begin
            r_pattern <= i_pattern;
            r_repeat  <= i_repeat;
            r_bit_idx <= IDX_TOP;
        end else if (o_shift_en) begin
            if (r_bit_idx != '0) begin
                r_bit_idx <= r_bit_idx - IDX_W'(1);
            end else if (r_repeat) begin
                // Wrap straight back to the MSB: no gap between passes.
                r_bit_idx <= IDX_TOP;
            end
        end
    end

    assign o_bit_idx = r_bit_idx;

endmodule

// File: tb/tb_led_shift_sequencer.sv
module tb_led_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;

    // DUT with TICK_DIV=4
    logic       i_start, i_repeat, i_stop;
    logic [9:0] i_pattern;
    logic       o_val, o_shift_en, o_busy, o_done;
    logic [3:0] o_bit_idx;

    // DUT with TICK_DIV=1
    logic       f_start, f_repeat, f_stop;
    logic [9:0] f_pattern;
    logic       f_val, f_shift_en, f_busy, f_done;
    logic [3:0] f_bit_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_shift_sequencer #(.WIDTH(10), .TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_pattern  (i_pattern),
        .i_repeat   (i_repeat),
        .i_stop     (i_stop),
        .o_val      (o_val),
        .o_shift_en (o_shift_en),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bit_idx  (o_bit_idx)
    );

    led_shift_sequencer #(.WIDTH(10), .TICK_DIV(1)) dut_fast (
        .clk        (clk),
        .reset      (reset),
        .i_start    (f_start),
        .i_pattern  (f_pattern),
        .i_repeat   (f_repeat),
        .i_stop     (f_stop),
        .o_val      (f_val),
        .o_shift_en (f_shift_en),
        .o_busy     (f_busy),
        .o_done     (f_done),
        .o_bit_idx  (f_bit_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Present a start for one edge; returns in cycle N+1.
    task automatic start_dut(input logic [9:0] pat, input logic rep);
        i_start   = 1'b1;
        i_pattern = pat;
        i_repeat  = rep;
        next_cycle();
        i_start   = 1'b0;
    endtask

    // MSB-first expected streams, written out by hand
    logic exp_a [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_b [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 1'b1;
        i_start = 1'b0; i_repeat = 1'b0; i_stop = 1'b0; i_pattern = '0;
        f_start = 1'b0; f_repeat = 1'b0; f_stop = 1'b0; f_pattern = '0;
        next_cycle();
        next_cycle();

        // Reset state
        chk("rst_busy", o_busy, 0);
        chk("rst_val", o_val, 0);
        chk("rst_shift", o_shift_en, 0);
        chk("rst_done", o_done, 0);
        chk("rst_idx", o_bit_idx, 9);
        reset = 1'b0;
        next_cycle();

        // 1. Reset mid-playback after two shifts
        start_dut(10'h3FF, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            chk("t1_shift", o_shift_en, (k % 4 == 0) ? 1 : 0);
            chk("t1_val", o_val, 1);
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        chk("t1_busy", o_busy, 0);
        chk("t1_val0", o_val, 0);
        chk("t1_shift0", o_shift_en, 0);
        chk("t1_idx", o_bit_idx, 9);
        chk("t1_done", o_done, 0);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            chk("t1_no_done", o_done, 0);
            chk("t1_idle", o_busy, 0);
        end

        // 2. One-shot 10'b1011001110
        start_dut(10'b1011001110, 1'b0);
        for (int k = 1; k <= 42; k++) begin
            chk("t2_shift", o_shift_en, (k % 4 == 0 && k <= 40) ? 1 : 0);
            chk("t2_busy", o_busy, (k <= 40) ? 1 : 0);
            chk("t2_done", o_done, (k == 41) ? 1 : 0);
            if (k % 4 == 0 && k <= 40) begin
                chk("t2_val", o_val, exp_a[k/4 - 1]);
                chk("t2_idx", o_bit_idx, 10 - k/4);
            end
            if (k > 40) chk("t2_val_idle", o_val, 0);
            next_cycle();
        end

        // 3. Repeat with 10'h001, then stop on a terminal tick
        start_dut(10'h001, 1'b1);
        for (int k = 1; k <= 87; k++) begin
            chk("t3_shift", o_shift_en, (k % 4 == 0) ? 1 : 0);
            chk("t3_busy", o_busy, 1);
            chk("t3_done", o_done, 0);
            if (k % 4 == 0) chk("t3_val", o_val, ((k/4) % 10 == 0) ? 1 : 0);
            next_cycle();
        end
        // Cycle 88 is a terminal tick: stop must suppress the pulse
        i_stop = 1'b1;
        #1;
        chk("t3_stop_shift", o_shift_en, 0);
        chk("t3_stop_busy", o_busy, 1);
        next_cycle();
        i_stop = 1'b0;
        chk("t3_after_busy", o_busy, 0);
        chk("t3_after_val", o_val, 0);
        chk("t3_after_done", o_done, 0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            chk("t3_no_done", o_done, 0);
            chk("t3_no_shift", o_shift_en, 0);
        end

        // 4. Starts ignored in SHIFT and DONE; pattern changes ignored
        start_dut(10'h0F0, 1'b0);
        for (int k = 1; k <= 42; k++) begin
            if (k == 6) begin
                i_start = 1'b1; i_pattern = 10'h2AA;
            end else if (k == 41) begin
                i_start = 1'b1; i_pattern = 10'h3FF;
            end else begin
                i_start = 1'b0;
            end
            #1;
            chk("t4_shift", o_shift_en, (k % 4 == 0 && k <= 40) ? 1 : 0);
            chk("t4_busy", o_busy, (k <= 40) ? 1 : 0);
            chk("t4_done", o_done, (k == 41) ? 1 : 0);
            if (k % 4 == 0 && k <= 40) chk("t4_val", o_val, exp_b[k/4 - 1]);
            next_cycle();
        end
        i_start = 1'b0;
        // Start together with stop in IDLE
        i_start = 1'b1; i_stop = 1'b1;
        next_cycle();
        i_start = 1'b0; i_stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("t4_ss_busy", o_busy, 0);
            chk("t4_ss_shift", o_shift_en, 0);
            next_cycle();
        end

        // 5. TICK_DIV=1 with 10'h155
        f_start = 1'b1; f_pattern = 10'h155; f_repeat = 1'b0;
        next_cycle();
        f_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk("t5_shift", f_shift_en, (k <= 10) ? 1 : 0);
            chk("t5_busy", f_busy, (k <= 10) ? 1 : 0);
            chk("t5_done", f_done, (k == 11) ? 1 : 0);
            if (k <= 10) chk("t5_val", f_val, (k % 2 == 0) ? 1 : 0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
